// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver: register map,
// STATUS bit positions and the frame FSM state encoding.
package ps2_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;

  localparam int ST_NONEMPTY  = 0;
  localparam int ST_OVF       = 1;
  localparam int ST_PAR_ERR   = 2;
  localparam int ST_FRM_ERR   = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam logic [31:0] EMPTY_MARKER = 32'h0000_0100;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// CPU-side register bus of the keyboard receiver: strobed reads/writes,
// registered read data and a level interrupt back to the CPU.
interface ps2_keyboard_rx_if;
  logic [2:0]  addr;
  logic [31:0] data_in;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] data_out;
  logic        irq;

  modport master (output addr, data_in, write_enable, read_enable, input data_out, irq);
  modport slave  (input addr, data_in, write_enable, read_enable, output data_out, irq);
endinterface

// File: rtl/ps2_keyboard_rx_sync_fifo.sv
// Circular-buffer FIFO with a combinational head; a push into a full FIFO is
// accepted only when a pop happens in the same cycle, otherwise it is dropped.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deframes 11-bit frames
// into scan codes, queues them and exposes DATA/STATUS/CTRL registers plus irq.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_keyboard_rx_if.slave   bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic clk_prev, fall, din;

  // Lines idle high, so reset the synchronisers to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= (clk_sync << 1) | SYNC_STAGES'(ps2_clk);
      data_sync <= (data_sync << 1) | SYNC_STAGES'(ps2_data);
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign din  = data_sync[SYNC_STAGES-1];

  frame_state_t   state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           frm_push, set_par, set_frm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = (state_q == IDLE) ? '0 : tmo_q + 1'b1;
    frm_push  = 1'b0;
    set_par   = 1'b0;
    set_frm   = 1'b0;
    if (fall) begin
      tmo_d = '0;
      case (state_q)
        IDLE: if (!din) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = din;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!din)                  set_frm  = 1'b1;
          else if (^{shift_q, par_q}) frm_push = 1'b1;
          else                       set_par  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      tmo_d   = '0;
    end
  end

  logic [7:0]    head;
  logic          full, empty, rd_pop;
  logic [CW-1:0] count;

  assign rd_pop = bus.read_enable && (bus.addr == ADDR_DATA) && !empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (frm_push),
    .push_dat (shift_q),
    .pop      (rd_pop),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  logic        ovf, par_err, frm_err, irq_en, set_ovf;
  logic [2:0]  clr;
  logic [31:0] rd_data;
  logic        unused_data_in;

  assign unused_data_in = ^bus.data_in[31:4];
  assign set_ovf = frm_push & full & ~rd_pop;
  assign clr = (bus.write_enable && bus.addr == ADDR_STATUS) ? bus.data_in[3:1] : 3'b000;

  always_comb begin
    rd_data = '0;
    case (bus.addr)
      ADDR_DATA:   rd_data = empty ? EMPTY_MARKER : {24'b0, head};
      ADDR_STATUS: begin
        rd_data[ST_NONEMPTY]          = ~empty;
        rd_data[ST_OVF]               = ovf;
        rd_data[ST_PAR_ERR]           = par_err;
        rd_data[ST_FRM_ERR]           = frm_err;
        rd_data[ST_COUNT_LSB +: 8]    = 8'(count);
      end
      ADDR_CTRL:   rd_data[0] = irq_en;
      default:     rd_data = '0;
    endcase
  end

  // A flag set event in the same cycle as its W1C clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.data_out <= '0;
      bus.irq      <= 1'b0;
      ovf          <= 1'b0;
      par_err      <= 1'b0;
      frm_err      <= 1'b0;
      irq_en       <= 1'b0;
    end else begin
      frm_err <= set_frm | (frm_err & ~clr[2]);
      par_err <= set_par | (par_err & ~clr[1]);
      ovf     <= set_ovf | (ovf & ~clr[0]);
      if (bus.write_enable && bus.addr == ADDR_CTRL) irq_en <= bus.data_in[0];
      bus.irq <= irq_en & (~empty | ovf);
      if (bus.read_enable) bus.data_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench: reads push model-predicted data into a queue, a monitor
// compares data_out one cycle after each read strobe.
module tb_ps2_keyboard_rx;

  localparam int DEPTH = 8;
  localparam int TMO   = 300;
  localparam int HALF  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_keyboard_rx_if bus ();

  ps2_keyboard_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mq[$];
  logic [31:0] sbq[$];
  bit m_ovf, m_par, m_frm, m_irq_en;
  int checks = 0;
  int failures = 0;
  logic rd_dv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) rd_dv <= bus.read_enable;

  always @(negedge clk) begin
    if (rd_dv) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL read: got %h expected no read", bus.data_out);
      end else begin
        check("read", bus.data_out, sbq.pop_front());
      end
    end
  end

  function automatic logic [31:0] m_status();
    return {16'b0, 8'(mq.size()), 4'b0, m_frm, m_par, m_ovf, mq.size() != 0};
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return (mq.size() > 0) ? {24'b0, mq.pop_front()} : 32'h100;
      3'd1: return m_status();
      3'd2: return {31'b0, m_irq_en};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_rx(input logic [7:0] b, input int kind);
    if (kind == 2) m_frm = 1'b1;
    else if (kind == 1) m_par = 1'b1;
    else if (mq.size() == DEPTH) m_ovf = 1'b1;
    else mq.push_back(b);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] a);
    sbq.push_back(m_read(a));
    bus.addr = a;
    bus.read_enable = 1'b1;
    cyc(1);
    bus.read_enable = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.data_in = d;
    bus.write_enable = 1'b1;
    cyc(1);
    bus.write_enable = 1'b0;
    if (a == 3'd1) begin
      if (d[3]) m_frm = 1'b0;
      if (d[2]) m_par = 1'b0;
      if (d[1]) m_ovf = 1'b0;
    end else if (a == 3'd2) begin
      m_irq_en = d[0];
    end
  endtask

  task automatic chk_irq();
    cyc(2);
    check("irq", {31'b0, bus.irq}, {31'b0, m_irq_en & ((mq.size() != 0) | m_ovf)});
  endtask

  // kind: 0 good frame, 1 wrong parity, 2 stop bit low. nbits<11 gives a truncated frame.
  task automatic send_frame(input logic [7:0] b, input int kind, input int nbits, input bit pop_at_stop);
    logic [10:0] bits;
    bits = {(kind == 2) ? 1'b0 : 1'b1, (~^b) ^ (kind == 1), b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      if (pop_at_stop && i == 10) begin
        // Two synchroniser flops then edge detect: the stop bit is acted on at the third edge.
        cyc(2);
        sbq.push_back(m_read(3'd0));
        bus.addr = 3'd0;
        bus.read_enable = 1'b1;
        cyc(1);
        bus.read_enable = 1'b0;
        cyc(HALF - 3);
      end else begin
        cyc(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(HALF);
    if (nbits == 11) model_rx(b, kind);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_par = 1'b0;
    m_frm = 1'b0;
    m_irq_en = 1'b0;
  endtask

  initial begin
    bus.addr = 3'd0;
    bus.data_in = 32'h0;
    bus.write_enable = 1'b0;
    bus.read_enable = 1'b0;
    model_reset();
    rst_n = 1'b0;
    cyc(3);
    check("rst_data_out", bus.data_out, 32'h0);
    check("rst_irq", {31'b0, bus.irq}, 32'h0);
    rst_n = 1'b1;
    cyc(2);
    rd(3'd1);

    send_frame(8'h1C, 0, 11, 1'b0);
    rd(3'd1);
    rd(3'd0);
    rd(3'd0);

    send_frame(8'h1C, 1, 11, 1'b0);
    rd(3'd1);
    wr(3'd1, 32'h4);
    rd(3'd1);

    wr(3'd2, 32'h1);
    chk_irq();
    rd(3'd2);
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 11, 1'b0);
    rd(3'd1);
    chk_irq();
    for (int i = 0; i < 8; i++) rd(3'd0);
    rd(3'd1);
    chk_irq();
    wr(3'd1, 32'h2);
    chk_irq();

    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 0, 11, 1'b0);
    send_frame(8'($urandom), 0, 11, 1'b1);
    rd(3'd1);
    for (int i = 0; i < DEPTH; i++) rd(3'd0);

    send_frame(8'($urandom), 0, 5, 1'b0);
    cyc(TMO + 5);
    send_frame(8'hF0, 0, 11, 1'b0);
    rd(3'd1);
    rd(3'd0);

    send_frame(8'($urandom), 0, 11, 1'b0);
    send_frame(8'($urandom), 0, 11, 1'b0);
    send_frame(8'($urandom), 0, 5, 1'b0);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    model_reset();
    check("midframe_rst_data_out", bus.data_out, 32'h0);
    chk_irq();
    rd(3'd1);
    send_frame(8'h5A, 0, 11, 1'b0);
    rd(3'd0);

    for (int it = 0; it < 25; it++) begin
      int r;
      int n;
      r = $urandom_range(0, 7);
      send_frame(8'($urandom), (r < 2) ? r + 1 : 0, 11, 1'b0);
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) rd(3'($urandom_range(0, 7)));
      r = $urandom_range(0, 3);
      if (r == 0) wr(3'd1, $urandom & 32'hE);
      else if (r == 1) wr(3'd2, 32'($urandom_range(0, 1)));
      chk_irq();
    end
    rd(3'd1);

    cyc(3);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- Memory-mapped PS/2 keyboard receiver that sits beside `dual_timer` on the I/O side of `memory_selector`.
- Deserialises PS/2 frames into scan-code bytes and buffers them in a FIFO.
- Its read data feeds a new input of `mux_memoria_ula`. Its `irq` feeds `modulo_interrupcao` as a keyboard interrupt source.

Parameters:
- FIFO_DEPTH, 8, scan-code FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 50000, clk cycles without a PS/2 falling edge before a partial frame is discarded (1 ms at 50 MHz).
- SYNC_STAGES, 2, synchroniser flops on ps2_clk/ps2_data.

Ports:
- clk  in  1  system clock, 50 MHz domain; all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous.
- ps2_data  in  1  raw PS/2 data line, asynchronous.
- addr  in  3  register select (io_addr[2:0]).
- data_in  in  32  CPU write data.
- write_enable  in  1  single-cycle write strobe.
- read_enable  in  1  single-cycle read strobe.
- data_out  out  32  registered read data.
- irq  out  1  level interrupt request.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - data_out=0, irq=0, FIFO empty.
  - Sticky flags cleared, irq_en=0.
  - Frame FSM returns to IDLE, bit counter=0, timeout counter=0.
  - Reset mid-frame abandons the frame; nothing is pushed.
- Input conditioning:
  - ps2_clk and ps2_data each pass through SYNC_STAGES flops.
  - A falling edge is detected when the previous synced clk=1 and the current synced clk=0.
  - Data is sampled on that same cycle.
- Frame FSM, advancing only on falling edges:
  - IDLE: data=0 → DATA (bit_cnt=0); data=1 → stay (spurious edge ignored).
  - DATA: shift in LSB first; after 8 bits → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: data=1 and odd parity OK (XOR of 8 data bits and parity bit = 1) → push the byte. Parity failure → set par_err, no push. Stop bit=0 → set frm_err, no push. In every case → IDLE.
- Timeout:
  - The counter resets on every falling edge and on entry to IDLE.
  - In any state ≠ IDLE, reaching TIMEOUT_CYCLES returns the FSM to IDLE with no push and no flag.
- FIFO:
  - Circular buffer with rd_ptr/wr_ptr and a count (0..FIFO_DEPTH).
  - Push while full without a same-cycle pop: byte dropped, ovf flag set.
  - Same-cycle push and pop: both occur; count unchanged, including when full.
  - Pop while empty: no pointer change.
- Register map (reads):
  - addr 0 (DATA): data_out ← {24'b0, head byte}; pops if non-empty. If empty, data_out ← 32'h0000_0100 (bit 8 = empty marker), no pop.
  - addr 1 (STATUS): data_out ← {16'b0, count[7:0], 4'b0, frm_err, par_err, ovf, nonempty}.
  - addr 2 (CTRL): data_out ← {31'b0, irq_en}.
  - other addresses: data_out ← 0.
  - data_out updates on the edge where read_enable=1 (1-cycle latency) and holds otherwise.
- Register map (writes):
  - addr 1: each of data_in[3:1]=1 clears frm_err/par_err/ovf respectively (W1C). A set event in the same cycle wins.
  - addr 2: irq_en ← data_in[0].
  - other addresses: ignored.
- irq:
  - Registered; irq = irq_en & (nonempty | ovf), evaluated one cycle after the state change.
- Simultaneous read_enable and write_enable: both are honoured.

Decomposition:
- Package ps2_pkg holds:
  - address constants ADDR_DATA=3'd0, ADDR_STATUS=3'd1, ADDR_CTRL=3'd2;
  - STATUS bit indices;
  - FSM state typedef {IDLE, DATA, PARITY, STOP};
  - EMPTY_MARKER=32'h100.
- One sub-module, `sync_fifo`, parameterised on width and depth. It has push/pop/full/empty/count ports and supports simultaneous push and pop.

Test Plan:
- Send frame for 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz, then read addr 1 → STATUS bit0=1 and count=1. Read addr 0 → data_out=32'h1C. Read addr 0 again → 32'h100.
- Send 0x1C with parity=1 → no push; STATUS=32'h4. Write addr 1 data 32'h4 → STATUS=0.
- Set irq_en=1 and send 9 bytes 0x01..0x09 without reading → count=8, ovf=1, irq=1. Pops return 0x01..0x08 in order.
- With the FIFO full, pop addr 0 on the same clk cycle the 9th byte's stop edge is processed → count stays 8 and ovf stays 0.
- Send start bit plus 4 data bits, idle for TIMEOUT_CYCLES+5, then send a full 0xF0 frame → only 0xF0 is received; no error flags set.
- Assert rst_n=0 for 1 cycle mid-frame with 2 bytes queued → count=0, irq=0, data_out=0. The next complete frame is received correctly.
